// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: FSM encoding and readout selector indices.
package perf_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_CNT = 6;

    localparam logic [2:0] SEL_CYCLE      = 3'd0;
    localparam logic [2:0] SEL_INST       = 3'd1;
    localparam logic [2:0] SEL_ICACHE_REQ = 3'd2;
    localparam logic [2:0] SEL_ICACHE_HIT = 3'd3;
    localparam logic [2:0] SEL_DCACHE_REQ = 3'd4;
    localparam logic [2:0] SEL_DCACHE_HIT = 3'd5;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear and a freeze input.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !freeze && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Processor performance monitor: six saturating event counters that freeze a few
// cycles after a halt reaches EX/MEM, plus a registered 16-bit readout port.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        retire_regwrite,
    input  logic        retire_memwrite,
    input  logic        halt_in,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    input  logic        rd_en,
    input  logic [2:0]  rd_sel,
    input  logic        rd_hi,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done
);

    state_t      state, state_next;
    logic [31:0] drain_cnt, drain_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        if (clear) begin
            state_next = RUN;
            drain_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_in) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_next = DONE;
                        end else begin
                            state_next = DRAIN;
                            drain_next = 32'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        drain_next = drain_cnt - 32'd1;
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = RUN;
            endcase
        end
    end

    assign done = (state == DONE);

    // Increment strobes; freezing in DONE is handled inside each counter.
    logic [NUM_CNT-1:0] inc;
    assign inc[SEL_CYCLE]      = 1'b1;
    assign inc[SEL_INST]       = retire_regwrite | retire_memwrite | (halt_in & (state == RUN));
    assign inc[SEL_ICACHE_REQ] = icache_req;
    assign inc[SEL_ICACHE_HIT] = icache_hit & icache_req;
    assign inc[SEL_DCACHE_REQ] = dcache_req;
    assign inc[SEL_DCACHE_HIT] = dcache_hit & dcache_req;

    logic [CNT_W-1:0] cnt [8];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .clr    (clear),
                .inc    (inc[gi]),
                .freeze (done),
                .count  (cnt[gi])
            );
        end
        for (gi = NUM_CNT; gi < 8; gi++) begin : g_unused_sel
            assign cnt[gi] = '0;
        end
    endgenerate

    // Zero-extend to 32 bits so the upper half reads 0 for narrow counters.
    logic [31:0] sel_wide;
    logic [15:0] rd_word;
    assign sel_wide = 32'(cnt[rd_sel]);
    assign rd_word  = rd_hi ? sel_wide[31:16] : sel_wide[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed testbench for perf_monitor: a 32-bit instance with a 2-cycle drain and a
// 16-bit instance used for the saturation scenario.
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        retire_regwrite;
    logic        retire_memwrite;
    logic        halt_in;
    logic        icache_req;
    logic        icache_hit;
    logic        dcache_req;
    logic        dcache_hit;
    logic        rd_en;
    logic [2:0]  rd_sel;
    logic        rd_hi;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;

    logic        clear16;
    logic        rd_en16;
    logic [2:0]  rd_sel16;
    logic        rd_hi16;
    logic [15:0] rd_data16;
    logic        rd_valid16;
    logic        done16;
    logic        zero = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .retire_regwrite (retire_regwrite),
        .retire_memwrite (retire_memwrite),
        .halt_in         (halt_in),
        .icache_req      (icache_req),
        .icache_hit      (icache_hit),
        .dcache_req      (dcache_req),
        .dcache_hit      (dcache_hit),
        .rd_en           (rd_en),
        .rd_sel          (rd_sel),
        .rd_hi           (rd_hi),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .done            (done)
    );

    perf_monitor #(.CNT_W(16), .DRAIN_CYCLES(2)) dut16 (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear16),
        .retire_regwrite (zero),
        .retire_memwrite (zero),
        .halt_in         (zero),
        .icache_req      (zero),
        .icache_hit      (zero),
        .dcache_req      (zero),
        .dcache_hit      (zero),
        .rd_en           (rd_en16),
        .rd_sel          (rd_sel16),
        .rd_hi           (rd_hi16),
        .rd_data         (rd_data16),
        .rd_valid        (rd_valid16),
        .done            (done16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_async: done=%b rd_valid=%b rd_data=%h expected 0/0/0000", done, rd_valid, rd_data);
        end
        tick();
        tick();
        total++;
        if (done16 !== 1'b0 || rd_valid16 !== 1'b0 || rd_data16 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_held16: done=%b rd_valid=%b rd_data=%h expected 0/0/0000", done16, rd_valid16, rd_data16);
        end
        rst = 1'b0;
        $display("test_reset: checked");
    endtask

    task automatic test_regwrite();
        do_clear();
        retire_regwrite = 1'b1;
        repeat (10) tick();
        retire_regwrite = 1'b0;
        rd_en = 1'b1; rd_sel = 3'd1; rd_hi = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL inst10_valid_early: rd_valid=%b expected 0", rd_valid);
        end
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h000A) begin
            bad++;
            $display("FAIL inst10: rd_valid=%b rd_data=%h expected 1/000a", rd_valid, rd_data);
        end
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h000A) begin
            bad++;
            $display("FAIL inst10_hold: rd_valid=%b rd_data=%h expected 0/000a", rd_valid, rd_data);
        end
        $display("test_regwrite: inst read %h", rd_data);
    endtask

    task automatic test_both_retire();
        do_clear();
        retire_regwrite = 1'b1; retire_memwrite = 1'b1;
        repeat (3) tick();
        retire_regwrite = 1'b0; retire_memwrite = 1'b0;
        rd_en = 1'b1; rd_sel = 3'd1; rd_hi = 1'b0;
        tick();
        total++;
        if (rd_data !== 16'h0003) begin
            bad++;
            $display("FAIL inst_both: rd_data=%h expected 0003", rd_data);
        end
        rd_hi = 1'b1;
        tick();
        rd_en = 1'b0; rd_hi = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL inst_both_hi: rd_valid=%b rd_data=%h expected 1/0000", rd_valid, rd_data);
        end
        $display("test_both_retire: inst=3 checked");
    endtask

    task automatic test_cache();
        do_clear();
        icache_hit = 1'b1; icache_req = 1'b0;
        repeat (4) tick();
        icache_req = 1'b1;
        repeat (2) tick();
        icache_hit = 1'b0; icache_req = 1'b0;
        dcache_req = 1'b1; dcache_hit = 1'b0;
        tick();
        dcache_req = 1'b0;
        rd_en = 1'b1; rd_sel = 3'd2; rd_hi = 1'b0;
        tick();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0002) begin
            bad++;
            $display("FAIL icache_req: rd_valid=%b rd_data=%h expected 1/0002", rd_valid, rd_data);
        end
        rd_sel = 3'd3;
        tick();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0002) begin
            bad++;
            $display("FAIL icache_hit: rd_valid=%b rd_data=%h expected 1/0002", rd_valid, rd_data);
        end
        rd_sel = 3'd4;
        tick();
        total++;
        if (rd_data !== 16'h0001) begin
            bad++;
            $display("FAIL dcache_req: rd_data=%h expected 0001", rd_data);
        end
        rd_sel = 3'd5;
        tick();
        total++;
        if (rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL dcache_hit: rd_data=%h expected 0000", rd_data);
        end
        rd_sel = 3'd0;
        tick();
        rd_sel = 3'd6;
        tick();
        total++;
        if (rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL sel6: rd_data=%h expected 0000", rd_data);
        end
        rd_en = 1'b0; rd_sel = 3'd0;
        $display("test_cache: cache counters checked");
    endtask

    task automatic test_cycle();
        do_clear();
        repeat (4) tick();
        rd_en = 1'b1; rd_sel = 3'd0; rd_hi = 1'b0;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_data !== 16'h0004) begin
            bad++;
            $display("FAIL cycle4: rd_data=%h expected 0004", rd_data);
        end
        $display("test_cycle: cycle count %h", rd_data);
    endtask

    task automatic test_halt();
        do_clear();
        repeat (19) tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL halt_drain1: done=%b expected 0", done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL halt_drain2: done=%b expected 0", done);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL halt_done: done=%b expected 1", done);
        end
        halt_in = 1'b1; retire_regwrite = 1'b1;
        repeat (3) tick();
        halt_in = 1'b0; retire_regwrite = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL halt_second: done=%b expected 1", done);
        end
        rd_en = 1'b1; rd_sel = 3'd0; rd_hi = 1'b0;
        tick();
        total++;
        if (rd_data !== 16'd22) begin
            bad++;
            $display("FAIL halt_cycle_frozen: rd_data=%0d expected 22", rd_data);
        end
        rd_sel = 3'd1;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_data !== 16'd1) begin
            bad++;
            $display("FAIL halt_inst_frozen: rd_data=%0d expected 1", rd_data);
        end
        $display("test_halt: frozen after drain");
    endtask

    task automatic test_rst_drain();
        do_clear();
        repeat (3) tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (done !== 1'b0 || rd_data !== 16'h0000 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drain: done=%b rd_data=%h rd_valid=%b expected 0/0000/0", done, rd_data, rd_valid);
        end
        tick();
        rst = 1'b0;
        rd_en = 1'b1; rd_sel = 3'd0; rd_hi = 1'b0;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rst_counters_zero: rd_valid=%b rd_data=%h expected 1/0000", rd_valid, rd_data);
        end
        repeat (4) tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_done: done=%b expected 0", done);
        end
        $display("test_rst_drain: drain abandoned");
    endtask

    task automatic test_clear_halt();
        do_clear();
        repeat (5) tick();
        clear = 1'b1; halt_in = 1'b1;
        rd_en = 1'b1; rd_sel = 3'd0; rd_hi = 1'b0;
        tick();
        clear = 1'b0; halt_in = 1'b0;
        total++;
        if (rd_data !== 16'h0005) begin
            bad++;
            $display("FAIL clear_preread: rd_data=%h expected 0005", rd_data);
        end
        rd_sel = 3'd1;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL clear_halt_inst: rd_data=%h expected 0000", rd_data);
        end
        repeat (3) tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL clear_halt_state: done=%b expected 0", done);
        end
        rd_en = 1'b1; rd_sel = 3'd0;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_data !== 16'h0004) begin
            bad++;
            $display("FAIL clear_halt_cycle: rd_data=%h expected 0004", rd_data);
        end
        $display("test_clear_halt: clear wins over halt");
    endtask

    task automatic test_saturate();
        clear16 = 1'b1;
        tick();
        clear16 = 1'b0;
        repeat (70000) tick();
        rd_en16 = 1'b1; rd_sel16 = 3'd0; rd_hi16 = 1'b0;
        tick();
        total++;
        if (rd_valid16 !== 1'b1 || rd_data16 !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat16_lo: rd_valid=%b rd_data=%h expected 1/ffff", rd_valid16, rd_data16);
        end
        rd_hi16 = 1'b1;
        tick();
        total++;
        if (rd_data16 !== 16'h0000) begin
            bad++;
            $display("FAIL sat16_hi: rd_data=%h expected 0000", rd_data16);
        end
        rd_sel16 = 3'd7; rd_hi16 = 1'b0;
        tick();
        rd_en16 = 1'b0;
        total++;
        if (rd_data16 !== 16'h0000) begin
            bad++;
            $display("FAIL sat16_sel7: rd_data=%h expected 0000", rd_data16);
        end
        $display("test_saturate: 16-bit cycle counter saturation checked");
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0; retire_regwrite = 1'b0; retire_memwrite = 1'b0; halt_in = 1'b0;
        icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0;
        rd_en = 1'b0; rd_sel = 3'd0; rd_hi = 1'b0;
        clear16 = 1'b0; rd_en16 = 1'b0; rd_sel16 = 3'd0; rd_hi16 = 1'b0;

        test_reset();
        test_regwrite();
        test_both_retire();
        test_cache();
        test_cycle();
        test_halt();
        test_clear_halt();
        test_saturate();
        test_rst_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
